// File: rtl/tiny_pkg.sv
// Shared constants and FSM encoding for the tiny core host port.
package tiny_pkg;

  localparam int unsigned WORD_W         = 198;
  localparam int unsigned BYTES_PER_WORD = 25;
  localparam int unsigned ADDR_W         = 6;
  localparam int unsigned SHIFT_W        = BYTES_PER_WORD * 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_RUN,
    ST_RADDR,
    ST_RCAP,
    ST_SEND
  } host_state_t;

endpackage

// File: rtl/tiny_host_word_shifter.sv
// 25-byte shift register: bytes enter at the bottom, leave from the top,
// with a parallel load for result words and a byte-position counter.
module word_shifter
  import tiny_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [WORD_W-1:0] load_data_i,
  input  logic              shift_i,
  input  logic [7:0]        byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic [7:0]        top_byte_o,
  output logic              last_byte_o
);

  logic [SHIFT_W-1:0] sr_q, sr_d;
  logic [4:0]         cnt_q, cnt_d;

  assign last_byte_o = (cnt_q == 5'(BYTES_PER_WORD - 1));
  assign word_o      = sr_q[WORD_W-1:0];
  assign top_byte_o  = sr_q[SHIFT_W-1 -: 8];

  // Loaded words get two zero pad bits on top, so byte 0 goes out as {00, [197:192]}.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sr_d  = {{(SHIFT_W - WORD_W){1'b0}}, load_data_i};
      cnt_d = '0;
    end else if (shift_i) begin
      sr_d  = {sr_q[SHIFT_W-9:0], byte_i};
      cnt_d = last_byte_o ? '0 : cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tiny_host.sv
// Host driver for the tiny core: streams operand words in, runs the core,
// streams result words back out as bytes.
module tiny_host
  import tiny_pkg::*;
#(
  parameter int unsigned N_IN     = 6,
  parameter int unsigned IN_BASE  = 0,
  parameter int unsigned N_OUT    = 6,
  parameter int unsigned OUT_BASE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              busy,
  output logic [31:0]       run_cycles,
  output logic              core_reset,
  output logic              core_sel,
  output logic [ADDR_W-1:0] core_addr,
  output logic              core_w,
  output logic [WORD_W-1:0] core_data,
  input  logic [WORD_W-1:0] core_out,
  input  logic              core_done
);

  if (N_IN < 1 || N_IN > 64 || IN_BASE + N_IN > 64) begin : g_bad_in
    $error("tiny_host: N_IN/IN_BASE exceed core RAM");
  end
  if (N_OUT < 1 || N_OUT > 64 || OUT_BASE + N_OUT > 64) begin : g_bad_out
    $error("tiny_host: N_OUT/OUT_BASE exceed core RAM");
  end

  localparam logic [ADDR_W-1:0] LAST_IN    = ADDR_W'(N_IN - 1);
  localparam logic [ADDR_W-1:0] LAST_OUT   = ADDR_W'(N_OUT - 1);
  localparam logic [ADDR_W-1:0] IN_BASE_A  = ADDR_W'(IN_BASE);
  localparam logic [ADDR_W-1:0] OUT_BASE_A = ADDR_W'(OUT_BASE);

  host_state_t       state_q, state_d;
  logic [ADDR_W-1:0] widx_q, widx_d;
  logic [ADDR_W-1:0] ridx_q, ridx_d;
  logic [31:0]       run_q, run_d;

  logic              sh_load, sh_shift, sh_last;
  logic [WORD_W-1:0] sh_word;
  logic [7:0]        sh_top;

  word_shifter u_shifter (
    .clk         (clk),
    .rst_n       (reset),
    .load_i      (sh_load),
    .load_data_i (core_out),
    .shift_i     (sh_shift),
    .byte_i      (in_data),
    .word_o      (sh_word),
    .top_byte_o  (sh_top),
    .last_byte_o (sh_last)
  );

  assign run_cycles = run_q;

  always_comb begin
    state_d    = state_q;
    widx_d     = widx_q;
    ridx_d     = ridx_q;
    run_d      = run_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    busy       = (state_q != ST_IDLE);
    core_reset = 1'b1;
    core_sel   = 1'b1;
    core_w     = 1'b0;
    core_addr  = '0;
    core_data  = '0;
    sh_load    = 1'b0;
    sh_shift   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        widx_d   = '0;
        ridx_d   = '0;
        if (in_valid) begin
          sh_shift = 1'b1;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sh_shift = 1'b1;
          if (sh_last) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        core_w    = 1'b1;
        core_addr = IN_BASE_A + widx_q;
        core_data = sh_word;
        if (widx_q == LAST_IN) begin
          state_d = ST_RUN;
          run_d   = '0;
        end else begin
          widx_d  = widx_q + ADDR_W'(1);
          state_d = ST_LOAD;
        end
      end
      ST_RUN: begin
        core_reset = 1'b0;
        core_sel   = 1'b0;
        if (run_q != '1) run_d = run_q + 32'd1;
        if (core_done) state_d = ST_RADDR;
      end
      ST_RADDR: begin
        core_reset = 1'b0;
        core_addr  = OUT_BASE_A + ridx_q;
        state_d    = ST_RCAP;
      end
      ST_RCAP: begin
        core_reset = 1'b0;
        core_addr  = OUT_BASE_A + ridx_q;
        sh_load    = 1'b1;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        core_reset = 1'b0;
        out_valid  = 1'b1;
        out_data   = sh_top;
        if (out_ready) begin
          sh_shift = 1'b1;
          if (sh_last) begin
            if (ridx_q == LAST_OUT) begin
              state_d = ST_IDLE;
            end else begin
              ridx_d  = ridx_q + ADDR_W'(1);
              state_d = ST_RADDR;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      widx_q  <= '0;
      ridx_q  <= '0;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      ridx_q  <= ridx_d;
      run_q   <= run_d;
    end
  end

endmodule

// File: tb/tb_tiny_host.sv
// Scoreboard bench for tiny_host with a behavioural model of the tiny core RAM.
module tb_tiny_host;

  localparam int N_IN     = 2;
  localparam int IN_BASE  = 0;
  localparam int N_OUT    = 2;
  localparam int OUT_BASE = 4;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_data;
  logic         busy;
  logic [31:0]  run_cycles;
  logic         core_reset;
  logic         core_sel;
  logic [5:0]   core_addr;
  logic         core_w;
  logic [197:0] core_data;
  logic [197:0] core_out;
  logic         core_done;

  tiny_host #(
    .N_IN     (N_IN),
    .IN_BASE  (IN_BASE),
    .N_OUT    (N_OUT),
    .OUT_BASE (OUT_BASE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .run_cycles (run_cycles),
    .core_reset (core_reset),
    .core_sel   (core_sel),
    .core_addr  (core_addr),
    .core_w     (core_w),
    .core_data  (core_data),
    .core_out   (core_out),
    .core_done  (core_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]   addr;
    logic [197:0] data;
    bit           last;
  } wr_t;

  wr_t          wr_q[$];
  logic [7:0]   out_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;

  int           cur_done_at = 1;
  bit           cur_directed = 0;
  bit           tgl = 0;
  bit           done_seen = 0;
  int           done_cyc = 0;
  bit           want_lat = 0;
  bit           chk_raddr = 0;
  int           exp_run = 0;
  bit           fill_req = 0;
  logic [197:0] res_val [N_OUT];
  logic [197:0] mem [64];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [199:0] got, input logic [199:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic flag_fail(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got event expected none/in-bound", nm);
  endtask

  // Expected byte stream of one result word: 6 top bits in byte 0, then MSB-first bytes.
  task automatic push_result(input logic [197:0] r);
    out_q.push_back({2'b00, r[197:192]});
    for (int j = 1; j < 25; j++) out_q.push_back(r[199-8*j -: 8]);
  endtask

  // Core RAM model: synchronous write, registered read.
  always @(posedge clk) begin
    if (fill_req)
      for (int i = 0; i < N_OUT; i++) mem[OUT_BASE+i] <= res_val[i];
    if (core_sel && core_w) mem[core_addr] <= core_data;
    core_out <= mem[core_addr];
  end

  // Core behaviour: done after cur_done_at RUN cycles; random stray done elsewhere.
  initial begin : core_proc
    int k;
    logic [197:0] r;
    k = 0;
    core_done = 1'b0;
    forever begin
      @(negedge clk);
      fill_req = 1'b0;
      if (!reset) begin
        k = 0;
        core_done = 1'b0;
        chk_raddr = 1'b0;
        continue;
      end
      if (chk_raddr) begin
        chk("raddr_sel_rst", {core_sel, core_reset}, 2'b10);
        chk("raddr_addr", core_addr, OUT_BASE);
        chk_raddr = 1'b0;
      end
      if (!core_reset && !core_sel) begin
        k++;
        chk("run_in_ready", in_ready, 1'b0);
        chk("run_no_write", core_w, 1'b0);
        if (k == cur_done_at) begin
          for (int i = 0; i < N_OUT; i++) begin
            if (cur_directed && i == 0) r = {6'h02, {24{8'hAA}}};
            else for (int j = 0; j < 25; j++) r = (r << 8) | 198'($urandom_range(0, 255));
            res_val[i] = r;
            push_result(r);
          end
          fill_req  = 1'b1;
          core_done = 1'b1;
          exp_run   = k;
          done_cyc  = cyc;
          done_seen = 1'b1;
          want_lat  = 1'b1;
          chk_raddr = 1'b1;
        end else begin
          core_done = 1'b0;
        end
      end else begin
        k = 0;
        core_done = ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Write monitor.
  initial begin : wr_mon
    wr_t e;
    bit  start_pend;
    start_pend = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        start_pend = 0;
        continue;
      end
      if (start_pend) begin
        chk("start_latency", {core_reset, core_sel}, 2'b00);
        start_pend = 0;
      end
      if (core_w) begin
        if (wr_q.size() == 0) begin
          flag_fail("unexpected_write");
        end else begin
          e = wr_q.pop_front();
          chk("wr_addr", core_addr, e.addr);
          chk("wr_data", core_data, e.data);
          chk("wr_sel", core_sel, 1'b1);
          start_pend = e.last;
        end
      end
    end
  end

  // Output sink and monitor.
  initial begin : out_mon
    bit         rdy;
    bit         held;
    logic [7:0] held_data;
    logic [7:0] e;
    rdy = 0;
    held = 0;
    held_data = '0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        held = 0;
        continue;
      end
      rdy = tgl ? !rdy : ($urandom_range(0, 2) != 0);
      out_ready = rdy;
      if (held) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_data", out_data, held_data);
      end
      held = 0;
      if (out_valid) begin
        if (want_lat) begin
          chk("done_to_out", cyc - done_cyc, 3);
          want_lat = 0;
        end
        if (rdy) begin
          if (out_q.size() == 0) flag_fail("unexpected_byte");
          else begin
            e = out_q.pop_front();
            chk("out_byte", out_data, e);
          end
        end else begin
          held = 1;
          held_data = out_data;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) flag_fail("in_ready_timeout");
    @(negedge clk);
  endtask

  // One host transaction; abort_bytes >= 0 resets mid-way through the last word.
  task automatic do_run(input int done_at, input bit directed, input bit tgl_in, input int abort_bytes);
    logic [7:0]   b [25];
    logic [197:0] d;
    bit           aborting;
    int           t;
    cur_done_at  = done_at;
    cur_directed = directed;
    tgl          = tgl_in;
    done_seen    = 0;
    aborting     = 0;
    for (int w = 0; w < N_IN; w++) begin
      d = '0;
      for (int j = 0; j < 25; j++) begin
        b[j] = 8'($urandom_range(0, 255));
        if (directed && w == 0 && j == 0) b[j] = 8'hC3;
        d = (d << 8) | 198'(b[j]);
      end
      aborting = (abort_bytes >= 0) && (w == N_IN - 1);
      if (!aborting) wr_q.push_back('{addr: 6'(IN_BASE + w), data: d, last: (w == N_IN - 1)});
      for (int j = 0; j < 25; j++) begin
        if (aborting && j == abort_bytes) break;
        send_byte(b[j]);
      end
    end
    if (aborting) begin
      in_valid = 1'b0;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("abort_busy", busy, 1'b0);
      chk("abort_core_reset", core_reset, 1'b1);
      chk("abort_in_ready", in_ready, 1'b1);
      chk("abort_run_cycles", run_cycles, 0);
      reset = 1'b1;
      @(negedge clk);
      return;
    end
    in_valid = 1'b1;
    in_data  = 8'h5A;
    t = 0;
    while (!done_seen && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!done_seen) flag_fail("done_timeout");
    in_valid = 1'b0;
    t = 0;
    while (busy && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (busy) flag_fail("busy_timeout");
    chk("run_cycles", run_cycles, exp_run);
    chk("idle_core_reset", core_reset, 1'b1);
  endtask

  initial begin : main
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_run_cycles", run_cycles, 0);
    chk("rst_core_reset", core_reset, 1'b1);
    chk("rst_core_sel", core_sel, 1'b1);
    chk("rst_core_w", core_w, 1'b0);
    chk("rst_core_addr", core_addr, 0);
    chk("rst_core_data", core_data, 0);
    reset = 1'b1;
    @(negedge clk);

    do_run(10, 1'b1, 1'b1, -1);
    do_run(1, 1'b0, 1'b0, -1);
    do_run(5, 1'b0, 1'b0, 12);
    for (int i = 0; i < 4; i++)
      do_run(int'($urandom_range(1, 14)), 1'b0, i[0], -1);

    repeat (5) @(negedge clk);
    chk("wr_queue_drained", wr_q.size(), 0);
    chk("out_queue_drained", out_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
